// File: rtl/pc_unit.sv
// Fetch-stage program counter with sequential/branch/jump/call/return selection
// and a circular return-address stack. pc_out is registered; no input->pc_out path.
module pc_unit #(
  parameter int ADDR_W    = 10,
  parameter int RESET_VEC = 0,
  parameter int STEP      = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           br_taken,
  input  logic [ADDR_W-1:0]              br_target,
  input  logic                           jmp,
  input  logic                           call,
  input  logic [ADDR_W-1:0]              jmp_target,
  input  logic                           ret,
  output logic [ADDR_W-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  // top is the next write slot; when full it already points at the oldest entry
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_m1;
  logic [ADDR_W-1:0] pc_seq;
  logic              ras_full;
  logic              ras_empty;
  logic              push;

  assign pc_seq    = pc_out + ADDR_W'(STEP);
  assign top_m1    = top - PTR_W'(1);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);
  assign push      = !stall && call && !ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= ADDR_W'(RESET_VEC);
      top           <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= 1'b0;
      if (!stall) begin
        if (ret) begin
          if (!ras_empty) begin
            pc_out    <= ras[top_m1];
            top       <= top_m1;
            ras_count <= ras_count - CNT_W'(1);
          end else begin
            pc_out        <= pc_seq;
            ras_underflow <= 1'b1;
          end
        end else if (call) begin
          pc_out <= jmp_target;
          top    <= top + PTR_W'(1);
          if (ras_full) ras_overflow <= 1'b1;
          else          ras_count    <= ras_count + CNT_W'(1);
        end else if (jmp) begin
          pc_out <= jmp_target;
        end else if (br_taken) begin
          pc_out <= br_target;
        end else begin
          pc_out <= pc_seq;
        end
      end
    end
  end

  // Stack storage needs no reset; occupancy is tracked by ras_count.
  always_ff @(posedge clk) begin
    if (!rst && push) ras[top] <= pc_seq;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit: reset, stall, edge sampling, call/ret, RAS overflow
// and underflow, address wrap, and reset overriding a pending call.
module tb_pc_unit;
  logic       clk = 1'b0;
  logic       rst, stall, br_taken, jmp, call, ret;
  logic [9:0] br_target, jmp_target;
  logic [9:0] pc_out;
  logic [2:0] ras_count;
  logic       ras_overflow, ras_underflow;
  int checks = 0;
  int errors = 0;

  pc_unit #(.ADDR_W(10), .RESET_VEC(0), .STEP(1), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .call(call), .jmp_target(jmp_target), .ret(ret), .pc_out(pc_out),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input int exp_pc, input int exp_cnt);
    check({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
    check({tag, "_cnt"}, 32'(ras_count), 32'(exp_cnt));
  endtask

  initial begin
    idle();
    br_target = 0; jmp_target = 0;

    // 1: reset then sequential
    rst = 1;
    tick(); chk_pc("rst0", 0, 0);
    check("rst0_ovf", 32'(ras_overflow), 0);
    check("rst0_unf", 32'(ras_underflow), 0);
    tick(); chk_pc("rst1", 0, 0);
    rst = 0;
    tick(); chk_pc("seq1", 1, 0);
    tick(); chk_pc("seq2", 2, 0);
    tick(); chk_pc("seq3", 3, 0);
    tick(); tick(); chk_pc("seq5", 5, 0);

    // 2: stall drops branch
    stall = 1; br_taken = 1; br_target = 40;
    tick(); chk_pc("stall1", 5, 0);
    tick(); chk_pc("stall2", 5, 0);
    idle();
    tick(); chk_pc("unstall", 6, 0);

    // 3: target changed between edges
    br_taken = 1; br_target = 25;
    #2 check("mid_cycle_pc", 32'(pc_out), 6);
    br_target = 32;
    tick(); chk_pc("br32", 32, 0);
    idle();

    // jmp outranks br_taken
    jmp = 1; jmp_target = 200; br_taken = 1; br_target = 300;
    tick(); chk_pc("jmp_over_br", 200, 0);
    idle();

    // 4: call / ret / call+ret with empty stack
    jmp = 1; jmp_target = 10;
    tick(); chk_pc("jmp10", 10, 0);
    idle(); call = 1; jmp_target = 100;
    tick(); chk_pc("call100", 100, 1);
    idle(); ret = 1;
    tick(); chk_pc("ret11", 11, 0);
    check("ret11_unf", 32'(ras_underflow), 0);
    call = 1; jmp_target = 500;
    tick(); chk_pc("callret", 12, 0);
    check("callret_unf", 32'(ras_underflow), 1);
    idle();
    tick(); chk_pc("after_unf", 13, 0);
    check("unf_pulse_end", 32'(ras_underflow), 0);

    // 5: overflow and wrap of circular stack
    jmp = 1; jmp_target = 0;
    tick(); chk_pc("jmp0", 0, 0);
    idle(); call = 1;
    jmp_target = 50; tick(); chk_pc("c1", 50, 1);
    jmp_target = 60; tick(); chk_pc("c2", 60, 2);
    jmp_target = 70; tick(); chk_pc("c3", 70, 3);
    jmp_target = 80; tick(); chk_pc("c4", 80, 4);
    check("c4_ovf", 32'(ras_overflow), 0);
    jmp_target = 90; tick(); chk_pc("c5", 90, 4);
    check("c5_ovf", 32'(ras_overflow), 1);
    idle(); ret = 1;
    tick(); chk_pc("r1", 81, 3);
    tick(); chk_pc("r2", 71, 2);
    tick(); chk_pc("r3", 61, 1);
    tick(); chk_pc("r4", 51, 0);
    tick(); chk_pc("r5", 52, 0);
    check("r5_unf", 32'(ras_underflow), 1);
    check("r5_ovf", 32'(ras_overflow), 1);
    idle();
    tick(); chk_pc("r5_after", 53, 0);
    check("r5_after_unf", 32'(ras_underflow), 0);
    check("ovf_sticky", 32'(ras_overflow), 1);

    // 6: wrap and reset over a call
    jmp = 1; jmp_target = 1023;
    tick(); chk_pc("jmp_top", 1023, 0);
    idle();
    tick(); chk_pc("wrap", 0, 0);
    call = 1; jmp_target = 7;
    tick(); chk_pc("call7", 7, 1);
    rst = 1;
    tick(); chk_pc("rst_call", 0, 0);
    check("rst_call_ovf", 32'(ras_overflow), 0);
    check("rst_call_unf", 32'(ras_underflow), 0);
    idle();
    tick(); chk_pc("post_rst", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
